fifo_sync_prog: RTL and testbench

- Single-clock parametrised FIFO; the next generation of the team's FIFO family.
- Supports any DEPTH ≥ 2, not only powers of two.
- Provides a live fill count, runtime-programmable almost-full and almost-empty thresholds, and a selectable read mode: fall-through or registered.
- Used as a general buffering element inside one clock domain, between pipeline stages and bus adapters.

---
 rtl/fifo_sync_prog_pkg.sv | 14 +
 rtl/fifo_sync_prog_counter_wrap.sv | 24 ++
 rtl/fifo_sync_prog.sv | 139 +++++++++++++
 tb/tb_fifo_sync_prog.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_prog_pkg.sv
// Shared FIFO-family types: the read-mode enum and the count-width helper
// used to size fill counters and threshold ports.
package fifo_pkg;

   typedef enum logic {
      FIFO_FALLTHROUGH = 1'b0,
      FIFO_REGISTERED  = 1'b1
   } fifo_mode_e;

   function automatic int fifo_cw(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_sync_prog_counter_wrap.sv
// Modulo-MAX up counter with explicit wrap compare, so MAX need not be a
// power of two. Used for the FIFO write and read pointers.
module counter_wrap #(
   parameter int MAX   = 4,
   parameter int WIDTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   output logic [WIDTH-1:0] o_count
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_count <= '0;
      end else if (i_enable) begin
         if (o_count == WIDTH'(MAX - 1))
            o_count <= '0;
         else
            o_count <= o_count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with any DEPTH >= 2, live fill count, programmable
// almost-full/almost-empty thresholds and fall-through or registered reads.
// Define FIFO_SYNC_PROG_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_sync_prog
   import fifo_pkg::*;
#(
   parameter int    DATA_WIDTH    = 8,
   parameter int    DEPTH         = 12,
   parameter int    REGISTERED    = 0,
   parameter string INSTANCE_NAME = "DEADF1F0",
   localparam int   CW            = fifo_cw(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_write,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic                  ow_wr_full,
   output logic                  ow_wr_almost_full,
   input  logic                  i_read,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_rd_valid,
   output logic                  ow_rd_empty,
   output logic                  ow_rd_almost_empty,
   output logic [CW-1:0]         o_count,
   input  logic [CW-1:0]         i_afull_thresh,
   input  logic [CW-1:0]         i_aempty_thresh
`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
   ,
   input  logic                  i_err_clr,
   output logic                  o_overflow,
   output logic                  o_underflow
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  wr_acc;
   logic                  rd_acc;

   // Accepts use this cycle's flags only; no bypass at full or empty.
   assign wr_acc = i_write && !ow_wr_full;
   assign rd_acc = i_read  && !ow_rd_empty;

   assign ow_wr_full         = (count == CW'(DEPTH));
   assign ow_rd_empty        = (count == '0);
   assign ow_wr_almost_full  = (count >= i_afull_thresh);
   assign ow_rd_almost_empty = (count <= i_aempty_thresh);
   assign o_count            = count;

   counter_wrap #(.MAX(DEPTH), .WIDTH(AW)) u_wr_ptr (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_enable (wr_acc),
      .o_count  (wr_ptr)
   );

   counter_wrap #(.MAX(DEPTH), .WIDTH(AW)) u_rd_ptr (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_enable (rd_acc),
      .o_count  (rd_ptr)
   );

   always_ff @(posedge i_clk) begin
      if (wr_acc)
         mem[wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count <= '0;
      end else begin
         unique case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   generate
      if (REGISTERED == int'(FIFO_REGISTERED)) begin : g_registered
         logic [DATA_WIDTH-1:0] rd_data_q;
         logic                  rd_valid_q;

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_valid_q <= rd_acc;
               if (rd_acc)
                  rd_data_q <= mem[rd_ptr];
            end
         end

         assign o_rd_data  = rd_data_q;
         assign o_rd_valid = rd_valid_q;
      end else begin : g_fallthrough
         // Forced to zero while empty so the output is clean out of reset.
         assign o_rd_data  = ow_rd_empty ? '0 : mem[rd_ptr];
         assign o_rd_valid = !ow_rd_empty;
      end
   endgenerate

`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
   // Clear wins over a same-cycle set so software never loses a clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else if (i_err_clr) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (i_write && ow_wr_full)
            o_overflow <= 1'b1;
         if (i_read && ow_rd_empty)
            o_underflow <= 1'b1;
      end
   end
`endif

`ifndef SYNTHESIS
   always @(posedge i_clk) begin
      if (i_rst_n) begin
         if (i_write && ow_wr_full)
            $display("%s: write while full dropped", INSTANCE_NAME);
         if (i_read && ow_rd_empty)
            $display("%s: read while empty ignored", INSTANCE_NAME);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: DEPTH=12 fall-through, DEPTH=6 wrap and
// DEPTH=4 registered instances; expected words tracked in queues.
module tb_fifo_sync_prog;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   num_checks = 0;
   int   num_fails  = 0;

   always #5 clk = ~clk;

   logic       a_write, a_read;
   logic [7:0] a_wr_data, a_rd_data;
   logic       a_full, a_afull, a_empty, a_aempty, a_rd_valid;
   logic [3:0] a_count, a_afull_th, a_aempty_th;
`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
   logic       a_err_clr, a_overflow, a_underflow;
`endif

   logic       b_write, b_read;
   logic [7:0] b_wr_data, b_rd_data;
   logic       b_full, b_afull, b_empty, b_aempty, b_rd_valid;
   logic [2:0] b_count, b_afull_th, b_aempty_th;
`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
   logic       b_err_clr, b_overflow, b_underflow;
`endif

   logic       c_write, c_read;
   logic [7:0] c_wr_data, c_rd_data;
   logic       c_full, c_afull, c_empty, c_aempty, c_rd_valid;
   logic [2:0] c_count, c_afull_th, c_aempty_th;
`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
   logic       c_err_clr, c_overflow, c_underflow;
`endif

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] qc[$];

   fifo_sync_prog #(.DATA_WIDTH(8), .DEPTH(12), .REGISTERED(0), .INSTANCE_NAME("FIFO_A")) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_write(a_write), .i_wr_data(a_wr_data),
      .ow_wr_full(a_full), .ow_wr_almost_full(a_afull), .i_read(a_read),
      .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid), .ow_rd_empty(a_empty),
      .ow_rd_almost_empty(a_aempty), .o_count(a_count),
      .i_afull_thresh(a_afull_th), .i_aempty_thresh(a_aempty_th)
`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
      , .i_err_clr(a_err_clr), .o_overflow(a_overflow), .o_underflow(a_underflow)
`endif
   );

   fifo_sync_prog #(.DATA_WIDTH(8), .DEPTH(6), .REGISTERED(0), .INSTANCE_NAME("FIFO_B")) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_write(b_write), .i_wr_data(b_wr_data),
      .ow_wr_full(b_full), .ow_wr_almost_full(b_afull), .i_read(b_read),
      .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .ow_rd_empty(b_empty),
      .ow_rd_almost_empty(b_aempty), .o_count(b_count),
      .i_afull_thresh(b_afull_th), .i_aempty_thresh(b_aempty_th)
`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
      , .i_err_clr(b_err_clr), .o_overflow(b_overflow), .o_underflow(b_underflow)
`endif
   );

   fifo_sync_prog #(.DATA_WIDTH(8), .DEPTH(4), .REGISTERED(1), .INSTANCE_NAME("FIFO_C")) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_write(c_write), .i_wr_data(c_wr_data),
      .ow_wr_full(c_full), .ow_wr_almost_full(c_afull), .i_read(c_read),
      .o_rd_data(c_rd_data), .o_rd_valid(c_rd_valid), .ow_rd_empty(c_empty),
      .ow_rd_almost_empty(c_aempty), .o_count(c_count),
      .i_afull_thresh(c_afull_th), .i_aempty_thresh(c_aempty_th)
`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
      , .i_err_clr(c_err_clr), .o_overflow(c_overflow), .o_underflow(c_underflow)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_afull_th = 4'd0;
      #1;
      num_checks++;
      if (a_count !== 4'd0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_aempty !== 1'b1) begin
         num_fails++;
         $display("[TB] FAIL reset_flags: count=%0d empty=%b full=%b aempty=%b, want 0 1 0 1",
                  a_count, a_empty, a_full, a_aempty);
      end
      num_checks++;
      if (a_afull !== 1'b1) begin
         num_fails++;
         $display("[TB] FAIL reset_afull_th0: got %b want 1", a_afull);
      end
      a_afull_th = 4'd10;
      #1;
      num_checks++;
      if (a_afull !== 1'b0) begin
         num_fails++;
         $display("[TB] FAIL reset_afull_th10: got %b want 0", a_afull);
      end
      num_checks++;
      if (a_rd_data !== 8'h00 || a_rd_valid !== 1'b0 || c_rd_data !== 8'h00 || c_rd_valid !== 1'b0) begin
         num_fails++;
         $display("[TB] FAIL reset_rd: a_data=%h a_valid=%b c_data=%h c_valid=%b, want 00 0 00 0",
                  a_rd_data, a_rd_valid, c_rd_data, c_rd_valid);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fill_drain();
      a_afull_th  = 4'd10;
      a_aempty_th = 4'd2;
      for (int i = 1; i <= 12; i++) begin
         a_write = 1'b1;
         a_wr_data = 8'(i);
         qa.push_back(8'(i));
         tick();
         num_checks++;
         if (a_count !== 4'(i) || a_afull !== (i >= 10) || a_full !== (i == 12)) begin
            num_fails++;
            $display("[TB] FAIL fill_%0d: count=%0d afull=%b full=%b, want %0d %b %b",
                     i, a_count, a_afull, a_full, i, (i >= 10), (i == 12));
         end
      end
      a_wr_data = 8'hEE;
      tick();
      a_write = 1'b0;
      num_checks++;
      if (a_count !== 4'd12 || a_full !== 1'b1) begin
         num_fails++;
         $display("[TB] FAIL drop_13th: count=%0d full=%b, want 12 1", a_count, a_full);
      end
      for (int i = 0; i < 12; i++) begin
         logic [7:0] exp_data;
         exp_data = qa.pop_front();
         num_checks++;
         if (a_rd_data !== exp_data) begin
            num_fails++;
            $display("[TB] FAIL drain_data_%0d: got %h want %h", i, a_rd_data, exp_data);
         end
         a_read = 1'b1;
         tick();
         num_checks++;
         if (a_count !== 4'(11 - i) || a_aempty !== ((11 - i) <= 2) || a_empty !== (i == 11)) begin
            num_fails++;
            $display("[TB] FAIL drain_flags_%0d: count=%0d aempty=%b empty=%b, want %0d %b %b",
                     i, a_count, a_aempty, a_empty, 11 - i, ((11 - i) <= 2), (i == 11));
         end
      end
      a_read = 1'b0;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 20; i++) begin
         logic [7:0] exp_data;
         b_write = 1'b1;
         b_wr_data = 8'(8'h30 + i);
         qb.push_back(8'(8'h30 + i));
         tick();
         b_write = 1'b0;
         exp_data = qb.pop_front();
         num_checks++;
         if (b_count !== 3'd1 || b_rd_data !== exp_data) begin
            num_fails++;
            $display("[TB] FAIL wrap_w%0d: count=%0d data=%h, want 1 %h", i, b_count, b_rd_data, exp_data);
         end
         b_read = 1'b1;
         tick();
         b_read = 1'b0;
         num_checks++;
         if (b_count !== 3'd0 || b_empty !== 1'b1) begin
            num_fails++;
            $display("[TB] FAIL wrap_r%0d: count=%0d empty=%b, want 0 1", i, b_count, b_empty);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] exp_data;
      for (int i = 0; i < 12; i++) begin
         a_write = 1'b1;
         a_wr_data = 8'(8'h80 + i);
         qa.push_back(8'(8'h80 + i));
         tick();
      end
      // Read+write at full: only the read may be accepted.
      a_wr_data = 8'h77;
      a_read = 1'b1;
      void'(qa.pop_front());
      tick();
      a_write = 1'b0;
      num_checks++;
      if (a_count !== 4'd11) begin
         num_fails++;
         $display("[TB] FAIL full_rw_count: got %0d want 11", a_count);
      end
      for (int i = 0; i < 11; i++) begin
         exp_data = qa.pop_front();
         num_checks++;
         if (a_rd_data !== exp_data) begin
            num_fails++;
            $display("[TB] FAIL full_rw_drain_%0d: got %h want %h", i, a_rd_data, exp_data);
         end
         tick();
      end
      num_checks++;
      if (a_empty !== 1'b1) begin
         num_fails++;
         $display("[TB] FAIL full_rw_empty: got %b want 1", a_empty);
      end
      // Read+write at empty: only the write may be accepted.
      a_write = 1'b1;
      a_wr_data = 8'h99;
      qa.push_back(8'h99);
      tick();
      a_write = 1'b0;
      a_read = 1'b0;
      exp_data = qa.pop_front();
      num_checks++;
      if (a_count !== 4'd1 || a_rd_data !== exp_data) begin
         num_fails++;
         $display("[TB] FAIL empty_rw: count=%0d data=%h, want 1 %h", a_count, a_rd_data, exp_data);
      end
      a_read = 1'b1;
      tick();
      a_read = 1'b0;
   endtask

   task automatic test_registered();
      logic [7:0] exp_data;
      c_write = 1'b1;
      c_wr_data = 8'hA5;
      qc.push_back(8'hA5);
      tick();
      c_wr_data = 8'h5A;
      qc.push_back(8'h5A);
      tick();
      c_write = 1'b0;
      num_checks++;
      if (c_rd_valid !== 1'b0 || c_count !== 3'd2) begin
         num_fails++;
         $display("[TB] FAIL reg_pre: valid=%b count=%0d, want 0 2", c_rd_valid, c_count);
      end
      c_read = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (i == 1) c_read = 1'b0;
         exp_data = qc.pop_front();
         num_checks++;
         if (c_rd_valid !== 1'b1 || c_rd_data !== exp_data) begin
            num_fails++;
            $display("[TB] FAIL reg_out_%0d: valid=%b data=%h, want 1 %h", i, c_rd_valid, c_rd_data, exp_data);
         end
      end
      tick();
      num_checks++;
      if (c_rd_valid !== 1'b0 || c_rd_data !== 8'h5A || c_empty !== 1'b1) begin
         num_fails++;
         $display("[TB] FAIL reg_post: valid=%b data=%h empty=%b, want 0 5a 1", c_rd_valid, c_rd_data, c_empty);
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] exp_data;
      for (int i = 0; i < 7; i++) begin
         a_write = 1'b1;
         a_wr_data = 8'(8'hC0 + i);
         qa.push_back(8'(8'hC0 + i));
         tick();
      end
      a_write = 1'b0;
      num_checks++;
      if (a_count !== 4'd7) begin
         num_fails++;
         $display("[TB] FAIL areset_pre_count: got %0d want 7", a_count);
      end
      c_write = 1'b1;
      c_wr_data = 8'h3C;
      tick();
      c_write = 1'b0;
      c_read = 1'b1;
      tick();
      c_read = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      qa.delete();
      qc.delete();
      num_checks++;
      if (a_count !== 4'd0 || a_empty !== 1'b1 || a_rd_valid !== 1'b0 ||
          c_rd_valid !== 1'b0 || c_rd_data !== 8'h00) begin
         num_fails++;
         $display("[TB] FAIL areset_mid: count=%0d empty=%b a_valid=%b c_valid=%b c_data=%h, want 0 1 0 0 00",
                  a_count, a_empty, a_rd_valid, c_rd_valid, c_rd_data);
      end
      tick();
      rst_n = 1'b1;
      tick();
      a_write = 1'b1;
      a_wr_data = 8'h42;
      qa.push_back(8'h42);
      tick();
      a_write = 1'b0;
      exp_data = qa.pop_front();
      num_checks++;
      if (a_count !== 4'd1 || a_rd_data !== exp_data) begin
         num_fails++;
         $display("[TB] FAIL areset_after: count=%0d data=%h, want 1 %h", a_count, a_rd_data, exp_data);
      end
      a_read = 1'b1;
      tick();
      a_read = 1'b0;
      num_checks++;
      if (a_empty !== 1'b1) begin
         num_fails++;
         $display("[TB] FAIL areset_after_empty: got %b want 1", a_empty);
      end
   endtask

`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
   task automatic test_err_flags();
      a_read = 1'b1;
      tick();
      a_read = 1'b0;
      num_checks++;
      if (a_underflow !== 1'b1 || a_overflow !== 1'b0) begin
         num_fails++;
         $display("[TB] FAIL underflow_set: uf=%b of=%b, want 1 0", a_underflow, a_overflow);
      end
      tick();
      num_checks++;
      if (a_underflow !== 1'b1) begin
         num_fails++;
         $display("[TB] FAIL underflow_sticky: got %b want 1", a_underflow);
      end
      a_err_clr = 1'b1;
      a_read = 1'b1;
      tick();
      a_err_clr = 1'b0;
      a_read = 1'b0;
      num_checks++;
      if (a_underflow !== 1'b0) begin
         num_fails++;
         $display("[TB] FAIL err_clr_priority: got %b want 0", a_underflow);
      end
      a_write = 1'b1;
      for (int i = 0; i < 12; i++) begin
         a_wr_data = 8'(i);
         tick();
      end
      num_checks++;
      if (a_overflow !== 1'b0 || a_full !== 1'b1) begin
         num_fails++;
         $display("[TB] FAIL overflow_pre: of=%b full=%b, want 0 1", a_overflow, a_full);
      end
      tick();
      a_write = 1'b0;
      num_checks++;
      if (a_overflow !== 1'b1) begin
         num_fails++;
         $display("[TB] FAIL overflow_set: got %b want 1", a_overflow);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      a_write = 0; a_read = 0; a_wr_data = 0; a_afull_th = 4'd10; a_aempty_th = 4'd2;
      b_write = 0; b_read = 0; b_wr_data = 0; b_afull_th = 3'd5;  b_aempty_th = 3'd0;
      c_write = 0; c_read = 0; c_wr_data = 0; c_afull_th = 3'd3;  c_aempty_th = 3'd1;
`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
      a_err_clr = 0; b_err_clr = 0; c_err_clr = 0;
`endif
      tick();
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simultaneous();
      test_registered();
      test_async_reset();
`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
      test_err_flags();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
